// File: rtl/fpmul_stream.sv
// fpmul_stream: ready/valid streaming wrapper around a fixed-latency pipelined
// single-precision multiplier (FPmul). Accepted operand pairs are tracked by a
// valid/tag shadow pipeline and collected in a credit-counted output FIFO, so
// no product is ever dropped under back-pressure.
// Optional feature: define FPMUL_STREAM_OPERANDS_EN to return out_a/out_b
// alongside every product.

// FPmul: IEEE-754 single multiplier, round-to-nearest-even. Subnormal inputs
// and results are flushed to signed zero; every NaN result is 0x7FC00000.
module FPmul #(
    parameter int LAT = 4
) (
    input  logic        clk,
    input  logic [31:0] FP_A,
    input  logic [31:0] FP_B,
    output logic [31:0] FP_Z
);
    logic [31:0]       zComb;
    logic [31:0]       stage [LAT];
    logic [47:0]       ma, mb, p;
    logic [24:0]       m;
    logic signed [9:0] e;
    logic              s, rnd, stk;
    logic              aNan, bNan, aInf, bInf, aZero, bZero;

    // Combinational product: classify operands, multiply significands, round.
    always_comb begin
        zComb = '0;
        s     = FP_A[31] ^ FP_B[31];
        aNan  = (FP_A[30:23] == 8'hFF) && (FP_A[22:0] != '0);
        bNan  = (FP_B[30:23] == 8'hFF) && (FP_B[22:0] != '0);
        aInf  = (FP_A[30:23] == 8'hFF) && (FP_A[22:0] == '0);
        bInf  = (FP_B[30:23] == 8'hFF) && (FP_B[22:0] == '0);
        aZero = (FP_A[30:23] == 8'h00);
        bZero = (FP_B[30:23] == 8'h00);
        ma    = {24'b0, 1'b1, FP_A[22:0]};
        mb    = {24'b0, 1'b1, FP_B[22:0]};
        p     = ma * mb;
        e     = $signed({2'b0, FP_A[30:23]}) + $signed({2'b0, FP_B[30:23]}) - 10'sd127;
        if (p[47]) begin
            m   = {1'b0, p[47:24]};
            rnd = p[23];
            stk = |p[22:0];
            e   = e + 10'sd1;
        end else begin
            m   = {1'b0, p[46:23]};
            rnd = p[22];
            stk = |p[21:0];
        end
        if (rnd && (stk || m[0])) begin
            m = m + 25'd1;
        end
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'sd1;
        end
        if (aNan || bNan || (aInf && bZero) || (bInf && aZero)) begin
            zComb = 32'h7FC00000;
        end else if (aInf || bInf) begin
            zComb = {s, 8'hFF, 23'h0};
        end else if (aZero || bZero) begin
            zComb = {s, 31'h0};
        end else if (e >= 10'sd255) begin
            zComb = {s, 8'hFF, 23'h0};
        end else if (e <= 10'sd0) begin
            zComb = {s, 31'h0};
        end else begin
            zComb = {s, e[7:0], m[22:0]};
        end
    end

    // Latency pipeline: the product appears LAT cycles after the operands are sampled.
    always_ff @(posedge clk) begin
        stage[0] <= zComb;
        for (int i = 1; i < LAT; i++) begin
            stage[i] <= stage[i-1];
        end
    end

    assign FP_Z = stage[LAT-1];
endmodule

module fpmul_stream #(
    parameter int PIPE_LAT   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [31:0]                      in_a,
    input  logic [31:0]                      in_b,
    input  logic [TAG_W-1:0]                 in_tag,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [31:0]                      out_data,
    output logic [TAG_W-1:0]                 out_tag,
`ifdef FPMUL_STREAM_OPERANDS_EN
    output logic [31:0]                      out_a,
    output logic [31:0]                      out_b,
`endif
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  used
);
    localparam int UW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {INIT, RUN} stateT;

    stateT               state, stateNext;
    logic                accept, pop, wrEn;
    logic [31:0]         coreZ;
    logic [PIPE_LAT-1:0] vld;
    logic [TAG_W-1:0]    tagPipe [PIPE_LAT];
    logic [31:0]         memZ    [FIFO_DEPTH];
    logic [TAG_W-1:0]    memTag  [FIFO_DEPTH];
    logic [PW-1:0]       wrPtr, rdPtr;
    logic [UW-1:0]       count;
`ifdef FPMUL_STREAM_OPERANDS_EN
    logic [31:0]         aPipe [PIPE_LAT];
    logic [31:0]         bPipe [PIPE_LAT];
    logic [31:0]         memA  [FIFO_DEPTH];
    logic [31:0]         memB  [FIFO_DEPTH];
`endif

    // Circular pointer advance that also handles non-power-of-two depths.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
        return (ptr == PW'(FIFO_DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    FPmul #(.LAT(PIPE_LAT)) core (
        .clk  (clk),
        .FP_A (in_a),
        .FP_B (in_b),
        .FP_Z (coreZ)
    );

    // Credit check never looks at out_ready, keeping in_ready free of combinational paths from downstream.
    assign in_ready  = (state == RUN) && (used < UW'(FIFO_DEPTH)) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign wrEn      = vld[PIPE_LAT-1];
    assign out_data  = out_valid ? memZ[rdPtr]   : '0;
    assign out_tag   = out_valid ? memTag[rdPtr] : '0;
`ifdef FPMUL_STREAM_OPERANDS_EN
    assign out_a     = out_valid ? memA[rdPtr]   : '0;
    assign out_b     = out_valid ? memB[rdPtr]   : '0;
`endif

    // State register: INIT holds off input for one cycle after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= stateNext;
    end

    // Next-state: INIT always moves to RUN, RUN is terminal.
    always_comb begin
        stateNext = state;
        case (state)
            INIT:    stateNext = RUN;
            RUN:     stateNext = RUN;
            default: stateNext = INIT;
        endcase
    end

    // Shadow valid pipeline: marks which core pipeline slots hold accepted operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        vld <= '0;
        else if (flush) vld <= '0;
        else            vld <= (vld << 1) | PIPE_LAT'(accept);
    end

    // Shadow sideband pipeline: only meaningful where the matching vld bit is set.
    always_ff @(posedge clk) begin
        tagPipe[0] <= in_tag;
`ifdef FPMUL_STREAM_OPERANDS_EN
        aPipe[0]   <= in_a;
        bPipe[0]   <= in_b;
`endif
        for (int i = 1; i < PIPE_LAT; i++) begin
            tagPipe[i] <= tagPipe[i-1];
`ifdef FPMUL_STREAM_OPERANDS_EN
            aPipe[i]   <= aPipe[i-1];
            bPipe[i]   <= bPipe[i-1];
`endif
        end
    end

    // FIFO storage write: core output lands at the write pointer when its op was accepted.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            memZ[wrPtr]   <= coreZ;
            memTag[wrPtr] <= tagPipe[PIPE_LAT-1];
`ifdef FPMUL_STREAM_OPERANDS_EN
            memA[wrPtr]   <= aPipe[PIPE_LAT-1];
            memB[wrPtr]   <= bPipe[PIPE_LAT-1];
`endif
        end
    end

    // Pointers, occupancy and credits; credits cover ops in flight plus queued results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            used  <= '0;
        end else begin
            if (wrEn) wrPtr <= nextPtr(wrPtr);
            if (pop)  rdPtr <= nextPtr(rdPtr);
            if (wrEn && !pop)      count <= count + UW'(1);
            else if (!wrEn && pop) count <= count - UW'(1);
            if (accept && !pop)      used <= used + UW'(1);
            else if (!accept && pop) used <= used - UW'(1);
        end
    end
endmodule

// File: tb/tb_fpmul_stream.sv
// tb_fpmul_stream: table-driven, directed and randomized checks of fpmul_stream
// against a cycle-level scoreboard and a double-precision product model.
// Honours FPMUL_STREAM_OPERANDS_EN when defined.
module tb_fpmul_stream;
    localparam int PIPE_LAT   = 4;
    localparam int FIFO_DEPTH = 6;
    localparam int TAG_W      = 4;
    localparam int UW         = $clog2(FIFO_DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]      in_a, in_b, out_data;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [UW-1:0]    used;
`ifdef FPMUL_STREAM_OPERANDS_EN
    logic [31:0]      out_a, out_b;
`endif

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      z;
    } vecT;

    typedef struct {
        logic [31:0]      z;
        logic [TAG_W-1:0] tag;
        logic [31:0]      a;
        logic [31:0]      b;
        int               due;
    } expT;

    expT         expQ[$];
    int          vecCount = 0;
    int          missCount = 0;
    int          cycle = 0;
    int          sinceRst = 0;
    int          modelUsed = 0;
    int          acceptTotal = 0;
    int          popTotal = 0;
    logic        lastAccept = 1'b0;
    logic [31:0] drvExp = '0;

    fpmul_stream #(.PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
`ifdef FPMUL_STREAM_OPERANDS_EN
        .out_a     (out_a),
        .out_b     (out_b),
`endif
        .used      (used)
    );

    always #5 clk = ~clk;

    // Single comparison point: bumps the counters and reports any difference.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Widen a single to a double with the same value (normal operands only).
    function automatic logic [63:0] toDouble(input logic [31:0] x);
        logic [10:0] ed;
        ed = 11'(int'(x[30:23]) + 896);
        return {x[31], ed, x[22:0], 29'd0};
    endfunction

    // Reference product: exact double product, then round-to-nearest-even to single.
    function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b);
        real         rp;
        logic [63:0] d;
        logic [23:0] mr;
        logic [28:0] rest;
        int          e;
        rp   = $bitstoreal(toDouble(a)) * $bitstoreal(toDouble(b));
        d    = $realtobits(rp);
        e    = int'(d[62:52]) - 1023 + 127;
        mr   = {1'b0, d[51:29]};
        rest = d[28:0];
        if (rest > 29'h10000000 || (rest == 29'h10000000 && mr[0])) mr = mr + 24'd1;
        if (mr[23]) begin
            mr = '0;
            e  = e + 1;
        end
        return {d[63], 8'(e), mr[22:0]};
    endfunction

    // Random normal operand whose products always stay in the normal range.
    function automatic logic [31:0] randOp();
        logic [7:0] ex;
        ex = 8'($urandom_range(189, 64));
        return {1'($urandom), ex, 23'($urandom)};
    endfunction

    // Tracks how many edges have passed since reset, giving the expected INIT->RUN timing.
    always @(posedge clk or posedge rst) begin
        if (rst) sinceRst <= 0;
        else if (sinceRst < 2) sinceRst <= sinceRst + 1;
    end

    // Cycle counter used to time-stamp when each result should become visible.
    always @(posedge clk) cycle <= cycle + 1;

    // Scoreboard: predicts handshakes, credits and the FIFO head each cycle, away from the clock edge.
    always @(negedge clk) begin
        logic expReady, headVis, acc, pop;
        if (rst) begin
            expQ.delete();
            modelUsed  = 0;
            lastAccept = 1'b0;
        end else begin
            expReady = (sinceRst >= 1) && (modelUsed < FIFO_DEPTH) && !flush;
            headVis  = (expQ.size() > 0) && (expQ[0].due <= cycle);
            checkOutput("inReady", {31'd0, in_ready}, {31'd0, expReady});
            checkOutput("used", 32'(used), 32'(modelUsed));
            checkOutput("outValid", {31'd0, out_valid}, {31'd0, headVis});
            if (headVis) begin
                checkOutput("outData", out_data, expQ[0].z);
                checkOutput("outTag", 32'(out_tag), 32'(expQ[0].tag));
`ifdef FPMUL_STREAM_OPERANDS_EN
                checkOutput("outA", out_a, expQ[0].a);
                checkOutput("outB", out_b, expQ[0].b);
`endif
            end
            pop = headVis && out_ready;
            acc = in_valid && expReady;
            if (flush) begin
                expQ.delete();
                modelUsed = 0;
            end else begin
                if (pop) begin
                    void'(expQ.pop_front());
                    popTotal++;
                end
                if (acc) begin
                    expQ.push_back('{z: drvExp, tag: in_tag, a: in_a, b: in_b, due: cycle + PIPE_LAT + 1});
                    acceptTotal++;
                end
                modelUsed = modelUsed + int'(acc) - int'(pop);
            end
            lastAccept = acc;
        end
    end

    // Offer one operand pair and hold it until the scoreboard sees it accepted.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t, input logic [31:0] z);
        int waitCycles;
        waitCycles = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
        drvExp   = z;
        do begin
            @(posedge clk); #1;
            waitCycles++;
        end while (!lastAccept && waitCycles < 200);
        checkOutput("acceptTimeout", {31'd0, lastAccept}, 32'd1);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
    endtask

    // Present a random operand pair for this cycle without waiting for acceptance.
    task automatic setRandomOp();
        in_valid = 1'b1;
        in_a     = randOp();
        in_b     = randOp();
        in_tag   = TAG_W'($urandom);
        drvExp   = refMul(in_a, in_b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Reset values must hold whenever rst is high, checked between edges.
    task automatic checkResetOutputs();
        checkOutput("rstInReady", {31'd0, in_ready}, 32'd0);
        checkOutput("rstOutValid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstOutData", out_data, 32'd0);
        checkOutput("rstOutTag", 32'(out_tag), 32'd0);
        checkOutput("rstUsed", 32'(used), 32'd0);
`ifdef FPMUL_STREAM_OPERANDS_EN
        checkOutput("rstOutA", out_a, 32'd0);
        checkOutput("rstOutB", out_b, 32'd0);
`endif
    endtask

    // Watchdog so the run always ends even if the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, table vectors, streaming, back-pressure, wrap, flush, random, async reset.
    initial begin
        vecT table_v[$];
        int  n, base, basePop;

        table_v = '{
            '{a: 32'h40000000, b: 32'h40400000, tag: 4'd1, z: 32'h40C00000},
            '{a: 32'hC0000000, b: 32'hC0400000, tag: 4'd2, z: 32'h40C00000},
            '{a: 32'h3FC00000, b: 32'hC0800000, tag: 4'd3, z: 32'hC0C00000},
            '{a: 32'h3F800000, b: 32'h3F800000, tag: 4'd4, z: 32'h3F800000},
            '{a: 32'h3F800001, b: 32'h3F800001, tag: 4'd5, z: 32'h3F800002},
            '{a: 32'h3FFFFFFF, b: 32'h3FFFFFFF, tag: 4'd6, z: 32'h407FFFFE},
            '{a: 32'h3F800001, b: 32'h3FC00000, tag: 4'd7, z: 32'h3FC00002},
            '{a: 32'h00000000, b: 32'h40000000, tag: 4'd8, z: 32'h00000000},
            '{a: 32'h80000000, b: 32'h40000000, tag: 4'd9, z: 32'h80000000},
            '{a: 32'h7F800000, b: 32'h40000000, tag: 4'd10, z: 32'h7F800000},
            '{a: 32'h7F800000, b: 32'h00000000, tag: 4'd11, z: 32'h7FC00000},
            '{a: 32'h7FC00000, b: 32'h3F800000, tag: 4'd12, z: 32'h7FC00000},
            '{a: 32'h7F000000, b: 32'h40000000, tag: 4'd13, z: 32'h7F800000},
            '{a: 32'h00800000, b: 32'h3F000000, tag: 4'd14, z: 32'h00000000}
        };

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_tag = '0;
        #12;
        checkResetOutputs();
        @(posedge clk); #3;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("inReadyFirstCycle", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        checkOutput("inReadySecondCycle", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Single op: exact PIPE_LAT+1 latency from accept to out_valid.
        applyStimulus(32'h40000000, 32'h40400000, 4'd3, 32'h40C00000);
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("singleLatency", 32'(n), 32'(PIPE_LAT + 1));
        checkOutput("singleData", out_data, 32'h40C00000);
        checkOutput("singleTag", 32'(out_tag), 32'd3);
        @(posedge clk); #1;

        // Table vectors, including rounding and special values.
        foreach (table_v[i]) applyStimulus(table_v[i].a, table_v[i].b, table_v[i].tag, table_v[i].z);
        idle(PIPE_LAT + 4);
        checkOutput("tableDrained", 32'(used), 32'd0);

        // Back-to-back stream of 16 ops with tags 0..15.
        base = acceptTotal;
        for (int i = 0; i < 16; i++) applyStimulus(32'h3FC00000, 32'hC0800000, TAG_W'(i), 32'hC0C00000);
        checkOutput("streamAccepts", 32'(acceptTotal - base), 32'd16);
        idle(PIPE_LAT + 4);

        // Back-pressure: exactly FIFO_DEPTH ops accepted, then in_ready drops.
        out_ready = 1'b0;
        base = acceptTotal;
        for (int i = 0; i < FIFO_DEPTH + 6; i++) begin
            setRandomOp();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checkOutput("fullAccepts", 32'(acceptTotal - base), 32'(FIFO_DEPTH));
        checkOutput("fullUsed", 32'(used), 32'(FIFO_DEPTH));
        checkOutput("fullInReady", {31'd0, in_ready}, 32'd0);
        basePop = popTotal;
        out_ready = 1'b1;
        idle(FIFO_DEPTH + PIPE_LAT + 2);
        checkOutput("fullPops", 32'(popTotal - basePop), 32'(FIFO_DEPTH));
        checkOutput("fullDrained", 32'(used), 32'd0);

        // Simultaneous accept and pop at used == FIFO_DEPTH-1 across several FIFO laps.
        out_ready = 1'b0;
        for (int i = 0; i < FIFO_DEPTH - 1; i++) applyStimulus(32'h40000000, 32'h40000000, TAG_W'(i), 32'h40800000);
        idle(PIPE_LAT + 1);
        checkOutput("wrapPreUsed", 32'(used), 32'(FIFO_DEPTH - 1));
        out_ready = 1'b1;
        base = acceptTotal;
        for (int i = 0; i < 3 * FIFO_DEPTH + 2; i++) begin
            setRandomOp();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checkOutput("wrapAccepts", 32'(acceptTotal - base), 32'(3 * FIFO_DEPTH + 2));
        checkOutput("wrapUsed", 32'(used), 32'(FIFO_DEPTH - 1));
        idle(FIFO_DEPTH + PIPE_LAT + 2);

        // Flush with 2 queued and 3 in flight; a following op still works.
        out_ready = 1'b0;
        applyStimulus(32'h40000000, 32'h40400000, 4'd1, 32'h40C00000);
        applyStimulus(32'h40000000, 32'h40400000, 4'd2, 32'h40C00000);
        idle(PIPE_LAT + 1);
        for (int i = 0; i < 3; i++) applyStimulus(32'h3FC00000, 32'hC0800000, TAG_W'(i + 4), 32'hC0C00000);
        flush = 1'b1;
        setRandomOp();
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        checkOutput("flushOutValid", {31'd0, out_valid}, 32'd0);
        checkOutput("flushUsed", 32'(used), 32'd0);
        idle(PIPE_LAT + 2);
        checkOutput("flushLateNoWrite", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        applyStimulus(32'h40000000, 32'h40400000, 4'd9, 32'h40C00000);
        idle(PIPE_LAT + 3);

        // Randomized traffic with random back-pressure and occasional flush.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9, 0) < 7) setRandomOp();
            else in_valid = 1'b0;
            out_ready = ($urandom_range(3, 0) != 0);
            flush     = ($urandom_range(63, 0) == 0);
            @(posedge clk); #1;
        end
        flush = 1'b0;

        // Async reset pulse between edges while results are queued.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            setRandomOp();
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs();
        #2;
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(1, 0) == 1) setRandomOp();
            else in_valid = 1'b0;
            out_ready = ($urandom_range(2, 0) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(FIFO_DEPTH + PIPE_LAT + 4);
        checkOutput("finalUsed", 32'(used), 32'd0);
        checkOutput("finalQueueEmpty", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
